// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one execute datapath (ALU, result-source mux and
// result register) between the main pipeline (requester 0) and the auxiliary
// address/branch unit (requester 1). One operation is in flight at a time:
// grant -> ISSUE (result register writes) -> CAPTURE (result returned).
module alu_share_arbiter #(
    parameter int PRIO_MODE = 0,   // 0 = round-robin, 1 = requester 0 always wins
    parameter int WIDTH     = 16
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             Req0,
    input  logic             Req1,
    input  logic [3:0]       Op0,
    input  logic [3:0]       Op1,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B0,
    input  logic [WIDTH-1:0] B1,
    input  logic             Src0,
    input  logic             Src1,
    output logic             Gnt0,
    output logic             Gnt1,
    output logic             Done0,
    output logic             Done1,
    output logic [WIDTH-1:0] RespData,
    output logic             RespZero,
    output logic             RespErr,
    output logic [WIDTH-1:0] ALUInA,
    output logic [WIDTH-1:0] ALUInB,
    output logic [3:0]       ALUop,
    output logic             ResSource,
    output logic             ResWrite,
    input  logic [WIDTH-1:0] ResOut,
    input  logic             isZero
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ERR} state_t;

    state_t           state, state_nxt;
    logic             last_gnt;
    logic             owner;
    logic             arb_en;
    logic             req_any;
    logic             grant;
    logic             winner;
    logic [3:0]       win_op;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic             win_src;
    logic             win_legal;

    // Datapath operand registers (stage-1 side of the shared execute unit)
    logic [WIDTH-1:0] alu_a_p1;
    logic [WIDTH-1:0] alu_b_p1;
    logic [3:0]       alu_op_p1;
    logic             res_src_p1;

    // Opcodes the shared ALU implements: AND, OR, ADD, SLT, SUB
    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd2, 4'd4, 4'd6: is_legal = 1'b1;
            default:                      is_legal = 1'b0;
        endcase
    endfunction

    // Arbitration: only open in IDLE/CAPTURE; held quiet while reset is asserted
    always_comb begin
        arb_en  = Reset_n && ((state == IDLE) || (state == CAPTURE));
        req_any = Req0 || Req1;
        if (Req0 && Req1)
            winner = (PRIO_MODE != 0) ? 1'b0 : ~last_gnt;
        else
            winner = Req1;
        win_op    = winner ? Op1  : Op0;
        win_a     = winner ? A1   : A0;
        win_b     = winner ? B1   : B0;
        win_src   = winner ? Src1 : Src0;
        win_legal = is_legal(win_op);
        grant     = arb_en && req_any;
        Gnt0      = grant && !winner;
        Gnt1      = grant && winner;
    end

    // Next-state logic; an illegal opcode short-cuts straight to the error reply
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, CAPTURE: begin
                if (grant)
                    state_nxt = win_legal ? ISSUE : ERR;
                else
                    state_nxt = IDLE;
            end
            ISSUE:   state_nxt = CAPTURE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Ownership and round-robin history; last_gnt=1 lets requester 0 win the first tie
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            last_gnt <= 1'b1;
            owner    <= 1'b0;
        end else if (grant) begin
            last_gnt <= winner;
            owner    <= winner;
        end
    end

    // Operand load: only legal grants touch the datapath, so CAPTURE holds isZero steady
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            alu_a_p1   <= '0;
            alu_b_p1   <= '0;
            alu_op_p1  <= '0;
            res_src_p1 <= 1'b0;
        end else if (grant && win_legal) begin
            alu_a_p1   <= win_a;
            alu_b_p1   <= win_b;
            alu_op_p1  <= win_op;
            res_src_p1 <= win_src;
        end
    end

    // Datapath drive and response to the owning requester
    always_comb begin
        ALUInA    = alu_a_p1;
        ALUInB    = alu_b_p1;
        ALUop     = alu_op_p1;
        ResSource = res_src_p1;
        ResWrite  = (state == ISSUE);
        Done0     = 1'b0;
        Done1     = 1'b0;
        RespData  = '0;
        RespZero  = 1'b0;
        RespErr   = 1'b0;
        if (state == CAPTURE) begin
            Done0    = !owner;
            Done1    = owner;
            RespData = ResOut;
            // isZero follows the ALU, so the shifter path needs its own zero test
            RespZero = res_src_p1 ? (ResOut == '0) : isZero;
        end else if (state == ERR) begin
            Done0   = !owner;
            Done1   = owner;
            RespErr = 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: table-driven vectors with a grant/done scoreboard, a
// behavioural stage-3 datapath, and hand-written contention/reset sequences.
module tb_alu_share_arbiter;

    localparam int W = 16;

    typedef struct {
        bit          who;
        logic [3:0]  op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit          src;
        logic [W-1:0] sh;
        logic [W-1:0] exp_data;
        bit          exp_zero;
        bit          exp_err;
    } vec_t;

    typedef struct {
        bit          who;
        logic [W-1:0] data;
        bit          zero;
        bit          err;
        int          gcyc;
    } exp_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic          Reset_n;
    logic          Req0, Req1;
    logic [3:0]    Op0, Op1;
    logic [W-1:0]  A0, A1, B0, B1;
    logic          Src0, Src1;
    logic          Gnt0, Gnt1, Done0, Done1, RespZero, RespErr;
    logic [W-1:0]  RespData, ALUInA, ALUInB, ResOut;
    logic [3:0]    ALUop;
    logic          ResSource, ResWrite, isZero;
    logic [W-1:0]  shifter_out;

    logic          p_gnt0, p_gnt1, p_done0, p_done1, p_zero, p_err, p_src, p_rw;
    logic [W-1:0]  p_data, p_a, p_b;
    logic [3:0]    p_op;

    alu_share_arbiter #(.PRIO_MODE(0), .WIDTH(W)) u_rr (
        .CLK(CLK), .Reset_n(Reset_n),
        .Req0(Req0), .Req1(Req1), .Op0(Op0), .Op1(Op1),
        .A0(A0), .A1(A1), .B0(B0), .B1(B1), .Src0(Src0), .Src1(Src1),
        .Gnt0(Gnt0), .Gnt1(Gnt1), .Done0(Done0), .Done1(Done1),
        .RespData(RespData), .RespZero(RespZero), .RespErr(RespErr),
        .ALUInA(ALUInA), .ALUInB(ALUInB), .ALUop(ALUop),
        .ResSource(ResSource), .ResWrite(ResWrite),
        .ResOut(ResOut), .isZero(isZero)
    );

    alu_share_arbiter #(.PRIO_MODE(1), .WIDTH(W)) u_prio (
        .CLK(CLK), .Reset_n(Reset_n),
        .Req0(Req0), .Req1(Req1), .Op0(Op0), .Op1(Op1),
        .A0(A0), .A1(A1), .B0(B0), .B1(B1), .Src0(Src0), .Src1(Src1),
        .Gnt0(p_gnt0), .Gnt1(p_gnt1), .Done0(p_done0), .Done1(p_done1),
        .RespData(p_data), .RespZero(p_zero), .RespErr(p_err),
        .ALUInA(p_a), .ALUInB(p_b), .ALUop(p_op),
        .ResSource(p_src), .ResWrite(p_rw),
        .ResOut(16'h0000), .isZero(1'b0)
    );

    // Behavioural stage-3 datapath behind the round-robin instance
    function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (op)
            4'd0:    alu_ref = a & b;
            4'd1:    alu_ref = a | b;
            4'd2:    alu_ref = a + b;
            4'd6:    alu_ref = a - b;
            4'd4:    alu_ref = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            default: alu_ref = '0;
        endcase
    endfunction

    assign isZero = (alu_ref(ALUop, ALUInA, ALUInB) == '0);

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n)
            ResOut <= '0;
        else if (ResWrite)
            ResOut <= ResSource ? shifter_out : alu_ref(ALUop, ALUInA, ALUInB);
    end

    int   cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    exp_t exp_r0, exp_r1;
    int   last_rw = -100;
    int   done_cnt = 0;
    int   rr_gnt_n = 0;
    int   rr_gnt_who[16];
    int   rr_gnt_cyc[16];
    bit   track = 1'b0;
    int   p_g0 = 0;
    int   p_g1_bad = 0;
    bit   p_g1_seen = 1'b0;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input bit who, input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input bit src, input logic [W-1:0] sh,
                                input logic [W-1:0] d, input bit z, input bit e);
        vec_t v;
        v.who = who; v.op = op; v.a = a; v.b = b; v.src = src; v.sh = sh;
        v.exp_data = d; v.exp_zero = z; v.exp_err = e;
        return v;
    endfunction

    // Scoreboard monitor: completions popped first, then the same cycle's grant pushed
    always @(negedge CLK) begin
        exp_t e;
        if (Done0 || Done1) begin
            done_cnt++;
            check("done_onehot", {31'd0, Done0 && Done1}, 0);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: actual=done0:%0b/done1:%0b required=none", Done0, Done1);
            end else begin
                e = sb.pop_front();
                check("done_who", {31'd0, Done1}, {31'd0, e.who});
                check("resp_data", {16'd0, RespData}, {16'd0, e.data});
                check("resp_zero", {31'd0, RespZero}, {31'd0, e.zero});
                check("resp_err", {31'd0, RespErr}, {31'd0, e.err});
                check("latency", cyc - e.gcyc, e.err ? 1 : 2);
                if (e.err)
                    check("no_reswrite_on_err", {31'd0, last_rw < e.gcyc}, 1);
                else
                    check("reswrite_cycle", last_rw, cyc - 1);
            end
        end
        if (Gnt0 || Gnt1) begin
            check("gnt_onehot", {31'd0, Gnt0 && Gnt1}, 0);
            e = Gnt1 ? exp_r1 : exp_r0;
            e.gcyc = cyc;
            sb.push_back(e);
            if (track && rr_gnt_n < 16) begin
                rr_gnt_who[rr_gnt_n] = Gnt1 ? 1 : 0;
                rr_gnt_cyc[rr_gnt_n] = cyc;
            end
            if (track) rr_gnt_n++;
        end
        if (ResWrite) last_rw = cyc;
        if (p_gnt0 && p_gnt1) check("prio_gnt_onehot", 1, 0);
        if (p_gnt0) p_g0++;
        if (p_gnt1 && Req0) p_g1_bad++;
        if (p_gnt1) p_g1_seen = 1'b1;
    end

    task automatic do_reset();
        @(negedge CLK);
        Reset_n = 1'b0;
        sb.delete();
        repeat (3) @(negedge CLK);
        Reset_n = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge CLK);
        check(name, sb.size(), 0);
    endtask

    task automatic wait_gnt(input bit who);
        bit got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge CLK);
            if (who ? Gnt1 : Gnt0) got = 1'b1;
        end
        check("gnt_seen", {31'd0, got}, 1);
    endtask

    task automatic run_op(input vec_t v);
        exp_t e;
        e.who = v.who; e.data = v.exp_data; e.zero = v.exp_zero; e.err = v.exp_err; e.gcyc = 0;
        shifter_out = v.sh;
        if (v.who) begin
            exp_r1 = e; Op1 = v.op; A1 = v.a; B1 = v.b; Src1 = v.src; Req1 = 1'b1;
        end else begin
            exp_r0 = e; Op0 = v.op; A0 = v.a; B0 = v.b; Src0 = v.src; Req0 = 1'b1;
        end
        wait_gnt(v.who);
        @(posedge CLK);
        #1;
        Req0 = 1'b0;
        Req1 = 1'b0;
        drain("op_drain");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   bad;
        int   d0;
        vec_t m;
        Reset_n = 1'b0;
        Req0 = 0; Req1 = 0; Op0 = 0; Op1 = 0; A0 = 0; A1 = 0; B0 = 0; B1 = 0;
        Src0 = 0; Src1 = 0; shifter_out = 0;

        vecs[0] = mk(0, 4'd2, 16'h0005, 16'hFFFC, 0, 16'h0000, 16'h0001, 0, 0);
        vecs[1] = mk(1, 4'd6, 16'h1234, 16'h1234, 0, 16'h0000, 16'h0000, 1, 0);
        vecs[2] = mk(1, 4'd6, 16'h1234, 16'h1234, 1, 16'h0007, 16'h0007, 0, 0);
        vecs[3] = mk(0, 4'd2, 16'h0001, 16'h0002, 1, 16'h0000, 16'h0000, 1, 0);
        vecs[4] = mk(0, 4'd0, 16'hF0F0, 16'h0FF0, 0, 16'h0000, 16'h00F0, 0, 0);
        vecs[5] = mk(1, 4'd1, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0);
        vecs[6] = mk(0, 4'd4, 16'hFFFF, 16'h0001, 0, 16'h0000, 16'h0001, 0, 0);
        vecs[7] = mk(1, 4'd2, 16'hFFFF, 16'h0001, 0, 16'h0000, 16'h0000, 1, 0);
        vecs[8] = mk(0, 4'hF, 16'h1111, 16'h2222, 0, 16'h0000, 16'h0000, 0, 1);
        vecs[9] = mk(1, 4'h3, 16'h3333, 16'h4444, 1, 16'h0000, 16'h0000, 0, 1);

        // Reset then idle
        repeat (3) @(negedge CLK);
        check("rst_gnt", {30'd0, Gnt0, Gnt1}, 0);
        check("rst_done", {30'd0, Done0, Done1}, 0);
        check("rst_resp", {14'd0, RespData, RespZero, RespErr}, 0);
        check("rst_alu", {ALUInA, ALUInB}, 0);
        check("rst_ctl", {26'd0, ALUop, ResSource, ResWrite}, 0);
        Reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (ResWrite || Gnt0 || Gnt1 || Done0 || Done1) bad++;
        end
        check("idle_quiet", bad, 0);

        // Vector table: legal ops, zero flag on both result paths, illegal opcodes
        for (int i = 0; i < 10; i++) run_op(vecs[i]);
        check("err_keeps_alu_a", {16'd0, ALUInA}, 32'h0000FFFF);
        check("err_keeps_alu_b", {16'd0, ALUInB}, 32'h00000001);
        check("err_keeps_alu_op", {28'd0, ALUop}, 2);

        // Reset during ISSUE aborts the op
        m = mk(0, 4'd2, 16'h0003, 16'h0004, 0, 16'h0000, 16'h0007, 0, 0);
        exp_r0.who = 0; exp_r0.data = 16'h0007; exp_r0.zero = 0; exp_r0.err = 0; exp_r0.gcyc = 0;
        Op0 = m.op; A0 = m.a; B0 = m.b; Src0 = 0; Req0 = 1'b1;
        wait_gnt(0);
        @(posedge CLK);
        #1;
        Req0 = 1'b0;
        @(negedge CLK);
        check("issue_reswrite", {31'd0, ResWrite}, 1);
        d0 = done_cnt;
        Reset_n = 1'b0;
        sb.delete();
        repeat (2) @(negedge CLK);
        check("midrst_alu_a", {16'd0, ALUInA}, 0);
        Reset_n = 1'b1;
        repeat (4) @(negedge CLK);
        check("abort_no_done", done_cnt - d0, 0);
        run_op(vecs[0]);

        // Contention: round-robin alternates, fixed priority starves requester 1
        do_reset();
        exp_r0.who = 0; exp_r0.data = 16'h0003; exp_r0.zero = 0; exp_r0.err = 0; exp_r0.gcyc = 0;
        exp_r1.who = 1; exp_r1.data = 16'hF000; exp_r1.zero = 0; exp_r1.err = 0; exp_r1.gcyc = 0;
        Op0 = 4'd2; A0 = 16'h0001; B0 = 16'h0002; Src0 = 0;
        Op1 = 4'd0; A1 = 16'hF0F0; B1 = 16'hFF00; Src1 = 0;
        shifter_out = 0;
        rr_gnt_n = 0; p_g0 = 0; p_g1_bad = 0; p_g1_seen = 1'b0;
        track = 1'b1;
        @(posedge CLK);
        #1;
        Req0 = 1'b1;
        Req1 = 1'b1;
        for (int n = 0; n < 60 && rr_gnt_n < 8; n++) @(negedge CLK);
        track = 1'b0;
        @(posedge CLK);
        #1;
        Req0 = 1'b0;
        check("rr_grant_count", rr_gnt_n, 8);
        for (int k = 0; k < 8; k++) begin
            check("rr_grant_order", rr_gnt_who[k], k % 2);
            if (k > 0) check("rr_grant_spacing", rr_gnt_cyc[k] - rr_gnt_cyc[k-1], 2);
        end
        check("prio_g0_count", p_g0, 8);
        check("prio_g1_while_req0", p_g1_bad, 0);
        for (int n = 0; n < 10 && !p_g1_seen; n++) @(negedge CLK);
        check("prio_g1_after_drop", {31'd0, p_g1_seen}, 1);
        @(posedge CLK);
        #1;
        Req1 = 1'b0;
        drain("contention_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
